// File: rtl/ibex_rf_write_arbiter_if.sv
// Write-port bundle between the EX/LSU issue side and the register-file write arbiter.
interface ibex_rf_write_arbiter_if #(
  parameter int DataWidth = 32
);
  logic                 ex_valid_i;
  logic                 ex_ready_o;
  logic [4:0]           ex_waddr_i;
  logic [DataWidth-1:0] ex_wdata_i;
  logic                 lsu_valid_i;
  logic [4:0]           lsu_waddr_i;
  logic [DataWidth-1:0] lsu_wdata_i;
  logic                 we_a_o;
  logic [4:0]           waddr_a_o;
  logic [DataWidth-1:0] wdata_a_o;
  logic [31:0]          busy_o;
  logic                 idle_o;

  modport slave (
    input  ex_valid_i, ex_waddr_i, ex_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output ex_ready_o, we_a_o, waddr_a_o, wdata_a_o, busy_o, idle_o
  );

  modport master (
    output ex_valid_i, ex_waddr_i, ex_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  ex_ready_o, we_a_o, waddr_a_o, wdata_a_o, busy_o, idle_o
  );
endinterface

// File: rtl/ibex_rf_write_arbiter.sv
// Merges LSU (unstalled, highest priority) and buffered EX results onto one registered RF write port.
// IBEX_RF_WRITE_BYPASS_EN lets an EX result skip the empty buffer straight into the output stage.
module ibex_rf_write_arbiter #(
  parameter int DataWidth = 32,
  parameter int Depth     = 2,
  parameter bit RV32E     = 1'b0
) (
  input logic                    clk_i,
  input logic                    rst_i,
  ibex_rf_write_arbiter_if.slave bus
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [4:0] AddrMask = RV32E ? 5'h0F : 5'h1F;

  logic [PtrW-1:0]      wr_ptr, rd_ptr;
  logic [CntW-1:0]      count;
  logic [Depth-1:0]     buf_vld;
  logic [4:0]           buf_addr [Depth];
  logic [DataWidth-1:0] buf_data [Depth];

  logic                 we_q;
  logic [4:0]           waddr_q;
  logic [DataWidth-1:0] wdata_q;

  logic [4:0] ex_addr, lsu_addr;
  logic       ex_ready, ex_accept, buf_empty, bypass_take, push, pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ex_addr   = bus.ex_waddr_i & AddrMask;
  assign lsu_addr  = bus.lsu_waddr_i & AddrMask;
  assign ex_ready  = count < CntW'(Depth);
  assign ex_accept = bus.ex_valid_i && ex_ready;
  assign buf_empty = (count == '0);

`ifdef IBEX_RF_WRITE_BYPASS_EN
  assign bypass_take = ex_accept && buf_empty && !bus.lsu_valid_i;
`else
  assign bypass_take = 1'b0;
`endif

  // x0 writes are acknowledged but never stored, so they can never reach the port.
  assign push = ex_accept && !bypass_take && (ex_addr != 5'd0);
  assign pop  = !bus.lsu_valid_i && !buf_empty;

  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_addr[wr_ptr] <= ex_addr;
      buf_data[wr_ptr] <= bus.ex_wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      buf_vld <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      if (push) begin
        buf_vld[wr_ptr] <= 1'b1;
        wr_ptr          <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        buf_vld[rd_ptr] <= 1'b0;
        rd_ptr          <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end

      if (bus.lsu_valid_i) begin
        we_q    <= (lsu_addr != 5'd0);
        waddr_q <= lsu_addr;
        wdata_q <= bus.lsu_wdata_i;
      end else if (pop) begin
        we_q    <= 1'b1;
        waddr_q <= buf_addr[rd_ptr];
        wdata_q <= buf_data[rd_ptr];
      end else if (bypass_take) begin
        we_q    <= (ex_addr != 5'd0);
        waddr_q <= ex_addr;
        wdata_q <= bus.ex_wdata_i;
      end else begin
        we_q <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.busy_o = '0;
    for (int i = 0; i < Depth; i++) begin
      if (buf_vld[i]) bus.busy_o[buf_addr[i]] = 1'b1;
    end
    if (we_q) bus.busy_o[waddr_q] = 1'b1;
    bus.busy_o[0] = 1'b0;
  end

  assign bus.ex_ready_o = ex_ready;
  assign bus.we_a_o     = we_q;
  assign bus.waddr_a_o  = waddr_q;
  assign bus.wdata_a_o  = wdata_q;
  assign bus.idle_o     = buf_empty && !we_q;
endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Directed bench for the RF write arbiter (default build, Depth=2) plus an RV32E instance.
module tb_ibex_rf_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ibex_rf_write_arbiter_if #(.DataWidth(32)) if0 ();
  ibex_rf_write_arbiter_if #(.DataWidth(32)) if1 ();

  ibex_rf_write_arbiter #(.DataWidth(32), .Depth(2), .RV32E(1'b0)) u_dut (
    .clk_i(clk), .rst_i(rst), .bus(if0)
  );
  ibex_rf_write_arbiter #(.DataWidth(32), .Depth(2), .RV32E(1'b1)) u_dut_e (
    .clk_i(clk), .rst_i(rst), .bus(if1)
  );

  typedef struct {
    logic        lv;
    logic [4:0]  la;
    logic [31:0] ld;
    logic        ev;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        rdy;
    logic [31:0] busy;
    logic        idle;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vt [21];

  function automatic vec_t mk(logic lv, logic [4:0] la, logic [31:0] ld,
                              logic ev, logic [4:0] ea, logic [31:0] ed,
                              logic we, logic [4:0] wa, logic [31:0] wd,
                              logic rdy, logic [31:0] busy, logic idle);
    vec_t v;
    v.lv = lv; v.la = la; v.ld = ld; v.ev = ev; v.ea = ea; v.ed = ed;
    v.we = we; v.wa = wa; v.wd = wd; v.rdy = rdy; v.busy = busy; v.idle = idle;
    return v;
  endfunction

  function automatic logic [31:0] b(int n);
    return 32'd1 << n;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive0(logic lv, logic [4:0] la, logic [31:0] ld,
                        logic ev, logic [4:0] ea, logic [31:0] ed);
    if0.lsu_valid_i = lv; if0.lsu_waddr_i = la; if0.lsu_wdata_i = ld;
    if0.ex_valid_i  = ev; if0.ex_waddr_i  = ea; if0.ex_wdata_i  = ed;
  endtask

  initial begin
    drive0(0, 0, 0, 0, 0, 0);
    if1.lsu_valid_i = 0; if1.lsu_waddr_i = 0; if1.lsu_wdata_i = 0;
    if1.ex_valid_i  = 0; if1.ex_waddr_i  = 0; if1.ex_wdata_i  = 0;

    // Rows: inputs applied this cycle, expected outputs seen before this cycle's edge.
    vt[0]  = mk(0,0,0,        0,0,0,            0,0,0,            1, 0, 1);
    vt[1]  = mk(0,0,0,        1,5,32'hDEADBEEF, 0,0,0,            1, 0, 1);
    vt[2]  = mk(0,0,0,        0,0,0,            0,0,0,            1, b(5), 0);
    vt[3]  = mk(0,0,0,        0,0,0,            1,5,32'hDEADBEEF, 1, b(5), 0);
    vt[4]  = mk(0,0,0,        0,0,0,            0,0,0,            1, 0, 1);
    vt[5]  = mk(1,7,32'h11,   1,3,32'h22,       0,0,0,            1, 0, 1);
    vt[6]  = mk(0,0,0,        0,0,0,            1,7,32'h11,       1, b(7)|b(3), 0);
    vt[7]  = mk(0,0,0,        0,0,0,            1,3,32'h22,       1, b(3), 0);
    vt[8]  = mk(0,0,0,        0,0,0,            0,0,0,            1, 0, 1);
    vt[9]  = mk(1,10,32'hA0,  1,1,32'h101,      0,0,0,            1, 0, 1);
    vt[10] = mk(1,11,32'hA1,  1,2,32'h102,      1,10,32'hA0,      1, b(10)|b(1), 0);
    vt[11] = mk(1,12,32'hA2,  1,3,32'h103,      1,11,32'hA1,      0, b(11)|b(1)|b(2), 0);
    vt[12] = mk(1,13,32'hA3,  1,3,32'h103,      1,12,32'hA2,      0, b(12)|b(1)|b(2), 0);
    vt[13] = mk(0,0,0,        1,3,32'h103,      1,13,32'hA3,      0, b(13)|b(1)|b(2), 0);
    vt[14] = mk(0,0,0,        1,3,32'h103,      1,1,32'h101,      1, b(1)|b(2), 0);
    vt[15] = mk(0,0,0,        0,0,0,            1,2,32'h102,      1, b(2)|b(3), 0);
    vt[16] = mk(0,0,0,        0,0,0,            1,3,32'h103,      1, b(3), 0);
    vt[17] = mk(0,0,0,        0,0,0,            0,0,0,            1, 0, 1);
    vt[18] = mk(0,0,0,        1,0,32'hFFFFFFFF, 0,0,0,            1, 0, 1);
    vt[19] = mk(0,0,0,        0,0,0,            0,0,0,            1, 0, 1);
    vt[20] = mk(0,0,0,        0,0,0,            0,0,0,            1, 0, 1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_we", {31'd0, if0.we_a_o}, 0);
    chk("reset_waddr", {27'd0, if0.waddr_a_o}, 0);
    chk("reset_wdata", if0.wdata_a_o, 0);
    chk("reset_busy", if0.busy_o, 0);
    chk("reset_idle", {31'd0, if0.idle_o}, 1);
    chk("reset_ready", {31'd0, if0.ex_ready_o}, 1);

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive0(vt[i].lv, vt[i].la, vt[i].ld, vt[i].ev, vt[i].ea, vt[i].ed);
      #1;
      chk($sformatf("row%0d_we", i), {31'd0, if0.we_a_o}, {31'd0, vt[i].we});
      if (vt[i].we) begin
        chk($sformatf("row%0d_waddr", i), {27'd0, if0.waddr_a_o}, {27'd0, vt[i].wa});
        chk($sformatf("row%0d_wdata", i), if0.wdata_a_o, vt[i].wd);
      end
      chk($sformatf("row%0d_ready", i), {31'd0, if0.ex_ready_o}, {31'd0, vt[i].rdy});
      chk($sformatf("row%0d_busy", i), if0.busy_o, vt[i].busy);
      chk($sformatf("row%0d_idle", i), {31'd0, if0.idle_o}, {31'd0, vt[i].idle});
    end

    // Fill the buffer behind two LSU writes, then reset with junk on the inputs.
    @(negedge clk);
    drive0(1, 20, 32'h20, 1, 4, 32'h44);
    @(negedge clk);
    drive0(1, 21, 32'h21, 1, 6, 32'h66);
    @(negedge clk);
    drive0(1, 9, 32'h99, 1, 8, 32'h88);
    rst = 1'b1;
    #1;
    chk("full_ready", {31'd0, if0.ex_ready_o}, 0);
    chk("full_busy", if0.busy_o, b(4)|b(6)|b(21));
    @(negedge clk);
    rst = 1'b0;
    drive0(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_mid_we", {31'd0, if0.we_a_o}, 0);
    chk("rst_mid_busy", if0.busy_o, 0);
    chk("rst_mid_idle", {31'd0, if0.idle_o}, 1);
    chk("rst_mid_ready", {31'd0, if0.ex_ready_o}, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst_drain%0d_we", i), {31'd0, if0.we_a_o}, 0);
    end

    // RV32E: address 5'h13 folds onto x3.
    @(negedge clk);
    if1.ex_valid_i = 1; if1.ex_waddr_i = 5'h13; if1.ex_wdata_i = 32'h5;
    @(negedge clk);
    if1.ex_valid_i = 0; if1.ex_waddr_i = 0; if1.ex_wdata_i = 0;
    #1;
    chk("e_busy_wait", if1.busy_o, b(3));
    chk("e_we_wait", {31'd0, if1.we_a_o}, 0);
    @(negedge clk);
    #1;
    chk("e_we", {31'd0, if1.we_a_o}, 1);
    chk("e_waddr", {27'd0, if1.waddr_a_o}, 3);
    chk("e_wdata", if1.wdata_a_o, 32'h5);
    chk("e_busy_issue", if1.busy_o, b(3));
    @(negedge clk);
    #1;
    chk("e_we_done", {31'd0, if1.we_a_o}, 0);
    chk("e_busy_done", if1.busy_o, 0);
    chk("e_idle_done", {31'd0, if1.idle_o}, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ibex_rf_write_arbiter.md
IBEX_RF_WRITE_ARBITER -- requirements
Module: ibex_rf_write_arbiter

Interface
REQ-001 Parameter: DataWidth, 32, width of write data.
REQ-002 Parameter: Depth, 2, EX-result buffer entries (legal 1..4).
REQ-003 Parameter: RV32E, 0, when 1 only 16 registers exist (4-bit addresses).
REQ-004 Port: clk_i  input  1  single clock, all state on rising edge.
REQ-005 Port: rst_i  input  1  reset, synchronous, active-high.
REQ-006 Port: ex_valid_i  input  1  EX result offered.
REQ-007 Port: ex_ready_o  output  1  EX result accepted this cycle when high with ex_valid_i.
REQ-008 Port: ex_waddr_i  input  5  EX destination register.
REQ-009 Port: ex_wdata_i  input  DataWidth  EX result data.
REQ-010 Port: lsu_valid_i  input  1  load result valid (no backpressure, always taken).
REQ-011 Port: lsu_waddr_i  input  5  load destination register.
REQ-012 Port: lsu_wdata_i  input  DataWidth  load data.
REQ-013 Port: we_a_o  output  1  register-file write enable, registered.
REQ-014 Port: waddr_a_o  output  5  register-file write address, registered.
REQ-015 Port: wdata_a_o  output  DataWidth  register-file write data, registered.
REQ-016 Port: busy_o  output  32  per-register pending-write scoreboard.
REQ-017 Port: idle_o  output  1  high when buffer empty and we_a_o low.

Function
REQ-018 Output stage loads every cycle with priority: LSU input, else buffer head, else (bypass, see Configuration) EX input, else we_a_o=0.
REQ-019 LSU write reaches we_a_o exactly 1 cycle after lsu_valid_i; it is never delayed.
REQ-020 ex_ready_o = buffer count < Depth, depending only on registered count (no same-cycle pop credit).
REQ-021 Accepted EX result not taken by bypass is pushed to buffer tail; buffer is strict FIFO.
REQ-022 Head pops only when output stage loads it (no LSU that cycle); push and pop in same cycle leave count unchanged.
REQ-023 Writes addressed to register 0 (after masking) are accepted/consumed but never produce we_a_o and never set busy_o.
REQ-024 RV32E=1: addresses masked to bits [3:0]; waddr_a_o[4] always 0; busy_o[31:16] always 0.
REQ-025 busy_o[n]=1 iff n is held in any valid buffer entry or in output stage with we_a_o=1; busy_o[0]=0 always.
REQ-026 Precondition: issuer never offers a write (EX or LSU) to a register with busy_o set; arbiter need not order such pairs.
REQ-027 Buffer pointers wrap modulo Depth; count never exceeds Depth nor underflows.
REQ-028 ex_valid_i with ex_ready_o low: no state change; EX data must be held stable by issuer.
REQ-029 idle_o combinational from registered state only.

Reset
REQ-030 rst_i high at a clock edge: buffer emptied, pointers and count 0, we_a_o=0, waddr_a_o=0, wdata_a_o=0, busy_o=0, idle_o=1, ex_ready_o=1 next cycle.
REQ-031 Reset mid-operation discards all buffered and staged writes; no write issues on the edge following reset.
REQ-032 Inputs during reset cycles are ignored.

Configuration
REQ-033 Macro IBEX_RF_WRITE_BYPASS_EN compiles the EX bypass path in or out.
REQ-034 Defined: when buffer empty and lsu_valid_i low, accepted EX write goes directly to output stage (latency 1, not pushed).
REQ-035 Not defined: every accepted EX write passes through buffer (minimum latency 2); behaviour otherwise identical.

Verification
REQ-036 Reset, then single EX write x5=0xDEADBEEF, buffer empty -> we_a_o=1, waddr_a_o=5 at cycle +1 (bypass) or +2 (no bypass); busy_o[5] set until write issued.
REQ-037 LSU x7=0x11 and EX x3=0x22 same cycle -> x7 written cycle +1, x3 cycle +2; busy_o[3] high during wait.
REQ-038 lsu_valid_i held high 4 cycles while EX offers x1..x3 with Depth=2 -> ex_ready_o low after 2 accepts; after LSU stops, x1 then x2 then x3 issue in order.
REQ-039 EX write to x0 data 0xFFFFFFFF -> accepted, we_a_o never asserts, busy_o stays 0, idle_o returns 1.
REQ-040 Buffer full (x4,x6), assert rst_i one cycle -> we_a_o=0 next cycle, busy_o=0, idle_o=1, ex_ready_o=1; neither x4 nor x6 ever written.
REQ-041 RV32E=1, EX write address 5'h13 data 0x5 -> waddr_a_o=3, busy_o[3] set, busy_o[19] never set.
